// File: rtl/count_sched_pkg.sv
// count_sched_pkg
//   Shared types and helpers for the count_sched round-robin counter scheduler.
//   - state_t  : scheduler FSM states
//   - DIR_UP/DIR_DN : direction encodings on the dir inputs
//   - rr_pick  : circular first-set-bit search starting at a pointer
package count_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // Widest requester vector rr_pick accepts; callers zero-extend into it.
   localparam int RR_MAX = 32;

   // Returns the index of the first set bit of req[0..n-1] at or after ptr,
   // wrapping around. Walks offsets high-to-low so the smallest offset from
   // ptr is the last assignment and therefore wins. Returns 0 if none set.
   function automatic int rr_pick(input logic [RR_MAX-1:0] req,
                                  input int n,
                                  input int ptr);
      int idx;
      int sel;
      sel = 0;
      for (int i = RR_MAX-1; i >= 0; i--) begin
         if (i < n) begin
            idx = ptr + i;
            if (idx >= n) idx = idx - n;
            if (req[idx]) sel = idx;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/updown_mod_counter.sv
// updown_mod_counter
//   Modular up/down counter, range 0..MOD-1. One step per enabled cycle.
//   Ports:
//     clk   in   clock
//     reset in   synchronous active-high reset (count=0, wrap=0)
//     en    in   step enable
//     up    in   1 = increment, 0 = decrement
//     count out  counter value
//     wrap  out  registered with the step that crossed the MOD-1 <-> 0 boundary
module updown_mod_counter #(
   parameter int W   = 4,
   parameter int MOD = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         up,
   output logic [W-1:0] count,
   output logic         wrap
);

   localparam logic [W-1:0] MAXV = W'(MOD-1);

   logic [W-1:0] r_count;
   logic         r_wrap;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
      end else if (en) begin
         if (up) begin
            if (r_count == MAXV) begin
               r_count <= '0;
               r_wrap  <= 1'b1;
            end else begin
               r_count <= r_count + 1'b1;
               r_wrap  <= 1'b0;
            end
         end else begin
            if (r_count == '0) begin
               r_count <= MAXV;
               r_wrap  <= 1'b1;
            end else begin
               r_count <= r_count - 1'b1;
               r_wrap  <= 1'b0;
            end
         end
      end else begin
         r_wrap <= 1'b0;
      end
   end

   assign count = r_count;
   assign wrap  = r_wrap;

endmodule

// File: rtl/count_sched.sv
// count_sched
//   Round-robin scheduler sharing one modular up/down counter among N_REQ
//   requesters. One burst of len single steps runs at a time, then done pulses
//   and arbitration restarts from the requester after the last winner.
//   Ports:
//     clk   in   clock
//     reset in   synchronous active-high reset
//     req   in   [N_REQ]        level requests
//     dir   in   [N_REQ]        per-requester direction (1 up, 0 down)
//     len   in   [N_REQ*LEN_W]  per-requester burst length
//     gnt   out  [N_REQ]        one-hot grant, held through the done cycle
//     busy  out  high while a burst is in progress (RUN/DONE)
//     done  out  one-cycle burst-complete pulse
//     count out  [W]            shared counter value
//     wrap  out  counter wrap pulse
module count_sched
   import count_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W     = 4,
   parameter int MOD   = 16,
   parameter int LEN_W = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ-1:0]       dir,
   input  logic [N_REQ*LEN_W-1:0] len,
   output logic [N_REQ-1:0]       gnt,
   output logic                   busy,
   output logic                   done,
   output logic [W-1:0]           count,
   output logic                   wrap
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t             r_state;
   logic [N_REQ-1:0]   r_gnt;
   logic [PW-1:0]      r_ptr;
   logic [PW-1:0]      r_win;
   logic [LEN_W-1:0]   r_rem;
   logic               r_cur_dir;
   // Zero-length bursts park one extra cycle in DONE before done pulses, so
   // done always lands at least one cycle after the grant appears.
   logic               r_zero;

   logic [RR_MAX-1:0]  w_req_ext;
   int                 w_pick;
   logic [N_REQ-1:0]   w_gnt_nxt;
   logic               w_dir_sel;
   logic [LEN_W-1:0]   w_len_sel;
   logic [PW-1:0]      w_ptr_nxt;

   always_comb begin
      w_req_ext = '0;
      w_req_ext[N_REQ-1:0] = req;
   end

   assign w_pick = rr_pick(w_req_ext, N_REQ, int'(r_ptr));

   // Mux out the winner's fields and build its one-hot grant.
   always_comb begin
      w_gnt_nxt = '0;
      w_dir_sel = DIR_DN;
      w_len_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_pick == i) begin
            w_gnt_nxt[i] = 1'b1;
            w_dir_sel    = dir[i];
            w_len_sel    = len[i*LEN_W +: LEN_W];
         end
      end
   end

   assign w_ptr_nxt = (r_win == PW'(N_REQ-1)) ? '0 : r_win + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_gnt     <= '0;
         r_ptr     <= '0;
         r_win     <= '0;
         r_rem     <= '0;
         r_cur_dir <= DIR_DN;
         r_zero    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|req) begin
                  r_gnt     <= w_gnt_nxt;
                  r_win     <= PW'(w_pick);
                  r_cur_dir <= w_dir_sel;
                  r_rem     <= w_len_sel;
                  if (w_len_sel == '0) begin
                     r_state <= DONE;
                     r_zero  <= 1'b1;
                  end else begin
                     r_state <= RUN;
                  end
               end
            end
            RUN: begin
               r_rem <= r_rem - 1'b1;
               if (r_rem == LEN_W'(1)) r_state <= DONE;
            end
            DONE: begin
               if (r_zero) begin
                  r_zero <= 1'b0;
               end else begin
                  r_state <= IDLE;
                  r_gnt   <= '0;
                  r_ptr   <= w_ptr_nxt;
               end
            end
            default: begin
               r_state <= IDLE;
               r_gnt   <= '0;
            end
         endcase
      end
   end

   updown_mod_counter #(
      .W   (W),
      .MOD (MOD)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (r_state == RUN),
      .up    (r_cur_dir),
      .count (count),
      .wrap  (wrap)
   );

   assign gnt  = r_gnt;
   assign busy = (r_state != IDLE);
   assign done = (r_state == DONE) && !r_zero;

endmodule

// File: tb/tb_count_sched.sv
module tb_count_sched;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req = '0, dir = '0;
   logic [15:0] len = '0;
   logic [3:0]  gnt, count;
   logic        busy, done, wrap;

   logic [3:0]  req2 = '0, dir2 = '0;
   logic [15:0] len2 = '0;
   logic [3:0]  gnt2, count2;
   logic        busy2, done2, wrap2;

   int pass_cnt = 0;
   int total    = 0;

   always #5 clk = ~clk;

   count_sched #(.N_REQ(4), .W(4), .MOD(16), .LEN_W(4)) dut (
      .clk(clk), .reset(reset), .req(req), .dir(dir), .len(len),
      .gnt(gnt), .busy(busy), .done(done), .count(count), .wrap(wrap));

   count_sched #(.N_REQ(4), .W(4), .MOD(10), .LEN_W(4)) dut10 (
      .clk(clk), .reset(reset), .req(req2), .dir(dir2), .len(len2),
      .gnt(gnt2), .busy(busy2), .done(done2), .count(count2), .wrap(wrap2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise one request, let the grant edge happen, then drop it.
   task automatic start(input int idx, input logic d, input int l);
      req[idx] = 1'b1;
      dir[idx] = d;
      len[idx*4 +: 4] = 4'(l);
      tick();
      req[idx] = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) tick();
      total++; if ({gnt, busy, done, wrap} !== 7'b0) $display("FAIL reset_ctl got=%b exp=0000000", {gnt, busy, done, wrap}); else pass_cnt++;
      total++; if (count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", count); else pass_cnt++;
      reset = 1'b0;
      tick();
      total++; if ({gnt, busy, done, count} !== 10'b0) $display("FAIL reset_idle got=%b exp=0", {gnt, busy, done, count}); else pass_cnt++;
      total++; if (count2 !== 4'd0 || busy2 !== 1'b0) $display("FAIL reset_dut10 got=%0d/%b exp=0/0", count2, busy2); else pass_cnt++;
   endtask

   task automatic test_single();
      int ec[4];
      ec = '{0, 1, 2, 3};
      start(1, 1'b1, 3);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         total++; if (gnt !== 4'b0010) $display("FAIL single_gnt[%0d] got=%b exp=0010", k, gnt); else pass_cnt++;
         total++; if (count !== 4'(ec[k])) $display("FAIL single_count[%0d] got=%0d exp=%0d", k, count, ec[k]); else pass_cnt++;
         total++; if (done !== (k == 3)) $display("FAIL single_done[%0d] got=%b exp=%b", k, done, (k == 3)); else pass_cnt++;
         total++; if (wrap !== 1'b0) $display("FAIL single_wrap[%0d] got=%b exp=0", k, wrap); else pass_cnt++;
         total++; if (busy !== 1'b1) $display("FAIL single_busy[%0d] got=%b exp=1", k, busy); else pass_cnt++;
      end
      tick();
      total++; if ({gnt, busy, done} !== 6'b0 || count !== 4'd3) $display("FAIL single_end got=%b/%0d exp=000000/3", {gnt, busy, done}, count); else pass_cnt++;
   endtask

   task automatic test_wrap();
      int cu[4], wu[4], cd[3], wd[3];
      cu = '{15, 0, 1, 2};  wu = '{0, 1, 0, 0};
      cd = '{1, 0, 15};     wd = '{0, 0, 1};
      start(3, 1'b1, 11);
      repeat (11) tick();
      total++; if (count !== 4'd14 || done !== 1'b1) $display("FAIL wrap_prep got=%0d/%b exp=14/1", count, done); else pass_cnt++;
      tick();
      start(3, 1'b1, 4);
      for (int k = 0; k < 4; k++) begin
         tick();
         total++; if (count !== 4'(cu[k]) || wrap !== 1'(wu[k])) $display("FAIL wrap_up[%0d] got=%0d/%b exp=%0d/%0d", k, count, wrap, cu[k], wu[k]); else pass_cnt++;
      end
      tick();
      total++; if (wrap !== 1'b0 || busy !== 1'b0) $display("FAIL wrap_up_idle got=%b/%b exp=0/0", wrap, busy); else pass_cnt++;
      start(3, 1'b0, 3);
      for (int k = 0; k < 3; k++) begin
         tick();
         total++; if (count !== 4'(cd[k]) || wrap !== 1'(wd[k])) $display("FAIL wrap_dn[%0d] got=%0d/%b exp=%0d/%0d", k, count, wrap, cd[k], wd[k]); else pass_cnt++;
      end
      total++; if (done !== 1'b1) $display("FAIL wrap_dn_done got=%b exp=1", done); else pass_cnt++;
      tick();
      total++; if (wrap !== 1'b0 || busy !== 1'b0) $display("FAIL wrap_dn_idle got=%b/%b exp=0/0", wrap, busy); else pass_cnt++;
   endtask

   task automatic test_round_robin();
      logic [3:0] eg;
      req = 4'b1111; dir = 4'b1111; len = 16'h1111;
      for (int b = 0; b < 5; b++) begin
         eg = 4'b0001 << (b % 4);
         tick();
         total++; if (gnt !== eg || done !== 1'b0) $display("FAIL rr_grant[%0d] got=%b/%b exp=%b/0", b, gnt, done, eg); else pass_cnt++;
         tick();
         total++; if (gnt !== eg || done !== 1'b1) $display("FAIL rr_done[%0d] got=%b/%b exp=%b/1", b, gnt, done, eg); else pass_cnt++;
         total++; if (count !== 4'(b) || wrap !== (b == 0)) $display("FAIL rr_count[%0d] got=%0d/%b exp=%0d/%b", b, count, wrap, b, (b == 0)); else pass_cnt++;
         tick();
         total++; if (gnt !== 4'b0 || busy !== 1'b0) $display("FAIL rr_idle[%0d] got=%b/%b exp=0000/0", b, gnt, busy); else pass_cnt++;
      end
      req = '0;
   endtask

   task automatic test_zero_len();
      start(2, 1'b1, 0);
      total++; if (gnt !== 4'b0100 || done !== 1'b0 || busy !== 1'b1) $display("FAIL zero_grant got=%b/%b/%b exp=0100/0/1", gnt, done, busy); else pass_cnt++;
      tick();
      total++; if (gnt !== 4'b0100 || done !== 1'b1 || count !== 4'd4) $display("FAIL zero_done got=%b/%b/%0d exp=0100/1/4", gnt, done, count); else pass_cnt++;
      tick();
      total++; if (gnt !== 4'b0 || busy !== 1'b0 || done !== 1'b0 || count !== 4'd4) $display("FAIL zero_idle got=%b/%b/%b/%0d exp=0000/0/0/4", gnt, busy, done, count); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int done_seen;
      start(1, 1'b1, 8);
      tick();
      total++; if (count !== 4'd5 || busy !== 1'b1) $display("FAIL mid_run got=%0d/%b exp=5/1", count, busy); else pass_cnt++;
      reset = 1'b1;
      tick();
      total++; if (count !== 4'd0 || gnt !== 4'b0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL mid_reset got=%0d/%b/%b/%b exp=0/0000/0/0", count, gnt, busy, done); else pass_cnt++;
      reset = 1'b0;
      len = '0;
      done_seen = 0;
      repeat (3) begin
         tick();
         if (done === 1'b1) done_seen++;
      end
      total++; if (done_seen !== 0) $display("FAIL mid_no_done got=%0d exp=0", done_seen); else pass_cnt++;
      // Before reset the pointer sat at 3; a reset pointer picks 1 over 3.
      req = 4'b1010;
      tick();
      req = '0;
      total++; if (gnt !== 4'b0010) $display("FAIL mid_ptr got=%b exp=0010", gnt); else pass_cnt++;
      repeat (2) tick();
      req = 4'b1000;
      tick();
      req = '0;
      total++; if (gnt !== 4'b1000) $display("FAIL mid_req3 got=%b exp=1000", gnt); else pass_cnt++;
      repeat (2) tick();
      total++; if (busy !== 1'b0 || count !== 4'd0) $display("FAIL mid_end got=%b/%0d exp=0/0", busy, count); else pass_cnt++;
   endtask

   task automatic test_mod10();
      int wraps;
      int over;
      int lens[2];
      lens = '{15, 10};
      wraps = 0;
      over = 0;
      for (int b = 0; b < 2; b++) begin
         req2[0] = 1'b1; dir2[0] = 1'b1; len2[3:0] = 4'(lens[b]);
         tick();
         req2[0] = 1'b0;
         for (int k = 0; k < lens[b]; k++) begin
            tick();
            if (wrap2 === 1'b1) wraps++;
            if (count2 > 4'd9) over++;
         end
         if (b == 0) begin
            total++; if (count2 !== 4'd5) $display("FAIL mod10_mid got=%0d exp=5", count2); else pass_cnt++;
         end
         tick();
      end
      total++; if (count2 !== 4'd5) $display("FAIL mod10_count got=%0d exp=5", count2); else pass_cnt++;
      total++; if (wraps !== 2) $display("FAIL mod10_wraps got=%0d exp=2", wraps); else pass_cnt++;
      total++; if (over !== 0) $display("FAIL mod10_range got=%0d exp=0", over); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_round_robin();
      test_zero_len();
      test_reset_mid();
      test_mod10();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
